// File: rtl/ultrasonido_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ranging engine across several sensors.
// Routes trigger/echo of the selected sensor, enforces timeout and guard interval, stores results.
module ultrasonido_scheduler #(
    parameter int NUM_SENSORS    = 2,
    parameter int COUNT_W        = 32,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GUARD_CYCLES   = 3_000_000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic [NUM_SENSORS-1:0]         echo_i,
    output logic [NUM_SENSORS-1:0]         trig_o,
    output logic                           eng_ready_o,
    output logic                           eng_abort_o,
    output logic                           eng_echo_o,
    input  logic                           eng_trigger_i,
    input  logic                           eng_done_i,
    input  logic [COUNT_W-1:0]             eng_count_i,
    output logic [NUM_SENSORS*COUNT_W-1:0] count_o,
    output logic [NUM_SENSORS-1:0]         valid_o,
    output logic [NUM_SENSORS-1:0]         timeout_o,
    output logic                           sample_o,
    output logic [2:0]                     sample_idx_o,
    output logic                           busy_o
);

    localparam int MAX_CYC = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [2:0]       SEL_LAST     = 3'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_MEASURE,
        S_ABORT,
        S_GUARD
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [2:0]               sel_reg, sel_next;
    logic                     done_wr, abort_wr;
    logic [NUM_SENSORS-1:0]   sel_onehot;
    logic                     sample_reg;
    logic [2:0]               sample_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        sel_next    = sel_reg;
        done_wr     = 1'b0;
        abort_wr    = 1'b0;
        eng_ready_o = 1'b0;
        eng_abort_o = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (enable_i) state_next = S_START;
            end
            S_START: begin
                eng_ready_o = 1'b1;
                cnt_next    = '0;
                state_next  = S_MEASURE;
            end
            S_MEASURE: begin
                cnt_next = cnt_reg + CNT_W'(1);
                // A completion on the final allowed cycle still counts as a good result.
                if (eng_done_i) begin
                    done_wr    = 1'b1;
                    cnt_next   = '0;
                    state_next = S_GUARD;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    cnt_next   = '0;
                    state_next = S_ABORT;
                end
            end
            S_ABORT: begin
                eng_abort_o = 1'b1;
                abort_wr    = 1'b1;
                cnt_next    = '0;
                state_next  = S_GUARD;
            end
            S_GUARD: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == GUARD_LAST) begin
                    cnt_next   = '0;
                    sel_next   = (sel_reg == SEL_LAST) ? 3'd0 : sel_reg + 3'd1;
                    state_next = enable_i ? S_START : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Per-sensor routing and result registers.
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sensor
        logic               valid_reg;
        logic               timeout_reg;
        logic [COUNT_W-1:0] count_reg;

        assign sel_onehot[gi] = (sel_reg == 3'(gi));
        assign trig_o[gi]     = sel_onehot[gi] & eng_trigger_i;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_reg   <= 1'b0;
                timeout_reg <= 1'b0;
                count_reg   <= '0;
            end else if (sel_onehot[gi]) begin
                if (done_wr) begin
                    valid_reg   <= 1'b1;
                    timeout_reg <= 1'b0;
                    count_reg   <= eng_count_i;
                end else if (abort_wr) begin
                    valid_reg   <= 1'b0;
                    timeout_reg <= 1'b1;
                end
            end
        end

        assign valid_o[gi]                     = valid_reg;
        assign timeout_o[gi]                   = timeout_reg;
        assign count_o[gi*COUNT_W +: COUNT_W]  = count_reg;
    end

    assign eng_echo_o = |(echo_i & sel_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_reg     <= 1'b0;
            sample_idx_reg <= '0;
        end else begin
            sample_reg <= done_wr | abort_wr;
            if (done_wr | abort_wr) sample_idx_reg <= sel_reg;
        end
    end

    assign sample_o     = sample_reg;
    assign sample_idx_o = sample_idx_reg;
    assign busy_o       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ultrasonido_scheduler.sv
// Randomized bench for ultrasonido_scheduler: an engine model drives measurements and a
// monitor compares every sample_o pulse against results queued by a behavioural model.
module tb_ultrasonido_scheduler;
    localparam int NS = 3;
    localparam int CW = 32;
    localparam int TO = 100;
    localparam int GD = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_i;
    logic [NS-1:0]    echo_i;
    logic [NS-1:0]    trig_o;
    logic             eng_ready_o, eng_abort_o, eng_echo_o;
    logic             eng_trigger_i, eng_done_i;
    logic [CW-1:0]    eng_count_i;
    logic [NS*CW-1:0] count_o;
    logic [NS-1:0]    valid_o, timeout_o;
    logic             sample_o;
    logic [2:0]       sample_idx_o;
    logic             busy_o;

    ultrasonido_scheduler #(
        .NUM_SENSORS(NS), .COUNT_W(CW), .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GD)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .echo_i(echo_i), .trig_o(trig_o),
        .eng_ready_o(eng_ready_o), .eng_abort_o(eng_abort_o), .eng_echo_o(eng_echo_o),
        .eng_trigger_i(eng_trigger_i), .eng_done_i(eng_done_i), .eng_count_i(eng_count_i),
        .count_o(count_o), .valid_o(valid_o), .timeout_o(timeout_o), .sample_o(sample_o),
        .sample_idx_o(sample_idx_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     idx;
        logic [NS-1:0]  v;
        logic [NS-1:0]  t;
        logic [NS*CW-1:0] c;
    } exp_t;

    exp_t          sbq[$];
    int            checks   = 0;
    int            failures = 0;
    logic [NS-1:0] m_valid, m_to;
    logic [CW-1:0] m_cnt[NS];
    int            exp_sel;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NS*CW-1:0] packed_counts();
        logic [NS*CW-1:0] v;
        for (int i = 0; i < NS; i++) v[i*CW +: CW] = m_cnt[i];
        return v;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_to    = '0;
        for (int i = 0; i < NS; i++) m_cnt[i] = '0;
        exp_sel = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},   128'(count_o),      128'(0));
        chk({tag, "_valid"},   128'(valid_o),      128'(0));
        chk({tag, "_timeout"}, 128'(timeout_o),    128'(0));
        chk({tag, "_sample"},  128'(sample_o),     128'(0));
        chk({tag, "_idx"},     128'(sample_idx_o), 128'(0));
        chk({tag, "_busy"},    128'(busy_o),       128'(0));
        chk({tag, "_ready"},   128'(eng_ready_o),  128'(0));
        chk({tag, "_abort"},   128'(eng_abort_o),  128'(0));
    endtask

    // Monitor: every result update must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sample_o === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=idx%0d required=no_sample", sample_idx_o);
            end else begin
                e = sbq.pop_front();
                chk("sample_idx",  128'(sample_idx_o), 128'(e.idx));
                chk("valid_vec",   128'(valid_o),      128'(e.v));
                chk("timeout_vec", 128'(timeout_o),    128'(e.t));
                chk("count_vec",   128'(count_o),      128'(e.c));
                $display("sample idx=%0d valid=%b timeout=%b count=%h", sample_idx_o, valid_o, timeout_o, count_o);
            end
        end
    end

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (eng_ready_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("wait_ready", 128'(got), 128'(1));
    endtask

    // Called at the negedge where eng_ready_o is high (offset 0). k = MEASURE cycle of done, -1 = none.
    task automatic measure(input int k, input logic [CW-1:0] c, input bit drop_en, input int rst_at);
        int            end_off;
        bit            good;
        bit            trg;
        logic [NS-1:0] ech;
        exp_t          e;
        good    = (k >= 0 && k <= TO - 1);
        end_off = good ? k + GD + 2 : TO + GD + 2;
        if (good) begin
            m_valid[exp_sel] = 1'b1;
            m_to[exp_sel]    = 1'b0;
            m_cnt[exp_sel]   = c;
        end else begin
            m_valid[exp_sel] = 1'b0;
            m_to[exp_sel]    = 1'b1;
        end
        e.idx = 3'(exp_sel);
        e.v   = m_valid;
        e.t   = m_to;
        e.c   = packed_counts();
        sbq.push_back(e);
        $display("measure sel=%0d done_cycle=%0d count=%0d expect_valid=%0d", exp_sel, k, c, good);
        for (int off = 1; off <= end_off; off++) begin
            @(negedge clk);
            eng_done_i  = (off == k + 1);
            eng_count_i = (off == k + 1) ? c : $urandom;
            if (off == 1) begin
                ech           = NS'($urandom);
                trg           = bit'($urandom_range(0, 1));
                echo_i        = ech;
                eng_trigger_i = trg;
                #1;
                chk("eng_echo",    128'(eng_echo_o),  128'(ech[exp_sel]));
                chk("trig_route",  128'(trig_o),      128'(trg ? (NS'(1) << exp_sel) : NS'(0)));
                chk("ready_pulse", 128'(eng_ready_o), 128'(0));
            end
            if (off == 2) begin
                echo_i = ech ^ ~(NS'(1) << exp_sel);
                #1;
                chk("echo_isolate", 128'(eng_echo_o), 128'(ech[exp_sel]));
            end
            if (drop_en && off == 5) enable_i = 1'b0;
            if (!good && off == TO)     chk("abort_early", 128'(eng_abort_o), 128'(0));
            if (!good && off == TO + 1) chk("abort_pulse", 128'(eng_abort_o), 128'(1));
            if (good && off == k + 2)   chk("no_abort",    128'(eng_abort_o), 128'(0));
            if (off == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk_reset_outputs("async_rst");
                eng_done_i = 1'b0;
                enable_i   = 1'b0;
                model_reset();
                return;
            end
            if (off == end_off - 1) chk("guard_not_ready", 128'(eng_ready_o), 128'(0));
            if (off == end_off) begin
                if (enable_i) begin
                    chk("next_ready", 128'(eng_ready_o), 128'(1));
                end else begin
                    chk("idle_ready", 128'(eng_ready_o), 128'(0));
                    chk("idle_busy",  128'(busy_o),      128'(0));
                end
            end
        end
        exp_sel = (exp_sel + 1) % NS;
    endtask

    initial begin
        int            k;
        logic [CW-1:0] c;
        rst           = 1'b1;
        enable_i      = 1'b0;
        echo_i        = '0;
        eng_trigger_i = 1'b0;
        eng_done_i    = 1'b0;
        eng_count_i   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 128'(busy_o), 128'(0));

        enable_i = 1'b1;
        wait_ready();
        measure(39, 32'd1234, 1'b0, 0);
        measure(15, 32'd10, 1'b0, 0);
        measure(60, 32'd20, 1'b0, 0);
        measure(5,  32'd30, 1'b0, 0);
        measure(70, 32'd40, 1'b0, 0);
        measure(-1, 32'd0,   1'b0, 0);
        measure(TO - 1, 32'd777, 1'b0, 0);
        measure(TO, 32'd555, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, TO + 5));
            c = $urandom;
            measure(k, c, 1'b0, 0);
        end

        measure(20, 32'd999, 1'b1, 0);
        repeat (10) @(negedge clk);
        chk("idle_hold_busy",  128'(busy_o),      128'(0));
        chk("idle_hold_ready", 128'(eng_ready_o), 128'(0));

        enable_i = 1'b1;
        wait_ready();
        measure(30, 32'd4242, 1'b0, 0);
        measure(10, 32'd88, 1'b0, 15);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        enable_i = 1'b1;
        wait_ready();
        measure(25, 32'd321, 1'b1, 0);
        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
